// File: rtl/huffman_pkg.sv
// Shared constants, code table and FSM state type for the Huffman front-end.
package huffman_pkg;

  localparam int MAX_LEN_CHUNK = 4;
  localparam int CODE_W        = 9;   // longest codeword
  localparam int NUM_CODES     = 10;

  typedef enum logic {IDLE = 1'b0, DECODE = 1'b1} fsm_state_t;

  // Codeword patterns are left-aligned in CODE_W bits; only the top len bits count.
  typedef struct packed {
    logic [CODE_W-1:0] pat;
    logic [3:0]        len;
    logic signed [3:0] val;
  } code_t;

  function automatic code_t code_entry(input int idx);
    code_t e;
    e = '0;
    case (idx)
      0: e = '{pat: 9'b000000000, len: 4'd1, val:  4'sd0};
      1: e = '{pat: 9'b100000000, len: 4'd2, val:  4'sd1};
      2: e = '{pat: 9'b110000000, len: 4'd3, val: -4'sd1};
      3: e = '{pat: 9'b111000000, len: 4'd4, val:  4'sd2};
      4: e = '{pat: 9'b111100000, len: 4'd5, val: -4'sd2};
      5: e = '{pat: 9'b111110000, len: 4'd6, val:  4'sd3};
      6: e = '{pat: 9'b111111000, len: 4'd7, val: -4'sd3};
      7: e = '{pat: 9'b111111100, len: 4'd8, val:  4'sd4};
      8: e = '{pat: 9'b111111110, len: 4'd9, val: -4'sd4};
      9: e = '{pat: 9'b111111111, len: 4'd9, val:  4'sd5};
      default: e = '0;
    endcase
    return e;
  endfunction

  // Mask selecting the top len bits of a CODE_W-bit head.
  function automatic logic [CODE_W-1:0] code_mask(input logic [3:0] len);
    return ~({CODE_W{1'b1}} >> len);
  endfunction

endpackage

// File: rtl/huffman_fsm.sv
// Two-state control: decides when the matched codeword is consumed.
module huffman_fsm
  import huffman_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] bit_count,
  input  logic             match,
  input  logic [3:0]       match_len,
  output logic             shift_en,
  output fsm_state_t       state
);

  fsm_state_t state_next;
  logic       len_ok;

  assign len_ok = (CNT_W'(match_len) <= bit_count) && (match_len != 4'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and consume strobe. The IDLE cycle that sees buffered bits is
  // the entry into DECODE, so it may already consume; otherwise the first
  // symbol of a burst would lag one cycle behind its completing chunk.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bit_count != '0) begin
          state_next = DECODE;
          shift_en   = match && len_ok;
        end
      end
      DECODE: begin
        shift_en = match && len_ok;
        // A registered count of zero means the last consume drained the
        // buffer and nothing was appended behind it.
        if (bit_count == '0) state_next = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/huffman_shift_reg.sv
// Streaming Huffman front-end: shift buffer, prefix match, append/consume.
module huffman_shift_reg
  import huffman_pkg::*;
#(
  parameter int MAX_CODE = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sValid,
  input  logic [3:0]        in_bits,
  input  logic [2:0]        in_len,
  output logic signed [3:0] decodedData,
  output logic              tvalid
);

  localparam int CNT_W  = $clog2(MAX_CODE + 1);
  localparam int WIDE_W = MAX_CODE + MAX_LEN_CHUNK;

  logic [MAX_CODE-1:0] shift_buf;
  logic [CNT_W-1:0]    bit_count;

  logic                match;
  logic [3:0]          match_len;
  logic signed [3:0]   match_val;
  logic                shift_en;
  fsm_state_t          fsm_state;

  logic [CODE_W-1:0]   head;
  code_t               entry;

  logic [CNT_W-1:0]    consumed, remaining, n, count_next;
  logic [2:0]          n_bits;
  logic                take;
  logic [3:0]          chunk_left;
  logic [WIDE_W-1:0]   chunk_wide;
  logic [MAX_CODE-1:0] kept, placed, buf_next;

  // Prefix match on the registered head; a code only counts if all of its
  // bits are inside the valid window. The code is prefix-free, so at most
  // one entry can hit.
  always_comb begin
    match     = 1'b0;
    match_len = '0;
    match_val = '0;
    entry     = '0;
    head      = shift_buf[MAX_CODE-1 -: CODE_W];
    for (int i = 0; i < NUM_CODES; i++) begin
      entry = code_entry(i);
      if (!match && (CNT_W'(entry.len) <= bit_count) &&
          ((head & code_mask(entry.len)) == entry.pat)) begin
        match     = 1'b1;
        match_len = entry.len;
        match_val = entry.val;
      end
    end
  end

  huffman_fsm #(.CNT_W(CNT_W)) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .bit_count (bit_count),
    .match     (match),
    .match_len (match_len),
    .shift_en  (shift_en),
    .state     (fsm_state)
  );

  // Consume then append: the chunk lands right behind the bits that survive
  // this edge's consume, and is dropped whole if it would not fit.
  always_comb begin
    consumed   = shift_en ? CNT_W'(match_len) : '0;
    remaining  = bit_count - consumed;
    n_bits     = (in_len > 3'd4) ? 3'd4 : in_len;
    n          = CNT_W'(n_bits);
    take       = sValid && (n_bits != 3'd0) &&
                 (({1'b0, remaining} + {1'b0, n}) <= (CNT_W+1)'(MAX_CODE));
    kept       = shift_buf << consumed;
    chunk_left = in_bits << (3'd4 - n_bits);
    chunk_wide = {chunk_left, {MAX_CODE{1'b0}}} >> remaining;
    placed     = chunk_wide[WIDE_W-1 -: MAX_CODE];
    buf_next   = take ? (kept | placed) : kept;
    count_next = remaining + (take ? n : '0);
  end

  // Buffer, count and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_buf   <= '0;
      bit_count   <= '0;
      tvalid      <= 1'b0;
      decodedData <= '0;
    end else begin
      shift_buf <= buf_next;
      bit_count <= count_next;
      tvalid    <= shift_en;
      if (shift_en) decodedData <= match_val;
    end
  end

endmodule

// File: tb/tb_huffman_shift_reg.sv
// Self-checking bench: directed plan sequences plus random stream vs a bit-queue model.
module tb_huffman_shift_reg;

  logic              clk = 1'b0;
  logic              reset;
  logic              sValid;
  logic [3:0]        in_bits;
  logic [2:0]        in_len;
  logic signed [3:0] decodedData;
  logic              tvalid;

  int n_vec  = 0;
  int n_fail = 0;

  bit q[$];          // buffered bits, oldest first
  int exp_tv = 0;
  int exp_d  = 0;

  huffman_shift_reg #(.MAX_CODE(9)) dut (
    .clk         (clk),
    .reset       (reset),
    .sValid      (sValid),
    .in_bits     (in_bits),
    .in_len      (in_len),
    .decodedData (decodedData),
    .tvalid      (tvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Unary-style code: k ones then a zero means value from k; nine ones is +5.
  function automatic void model_decode(output bit found, output int len, output int val);
    int ones = 0;
    found = 0; len = 0; val = 0;
    while (ones < q.size() && ones < 9 && q[ones] == 1'b1) ones++;
    if (ones == 9) begin
      found = 1; len = 9; val = 5;
    end else if (ones < q.size()) begin
      found = 1;
      len   = ones + 1;
      if (ones == 8)          val = -4;
      else if (ones == 0)     val = 0;
      else if (ones % 2 == 1) val = (ones + 1) / 2;
      else                    val = -(ones / 2);
    end
  endfunction

  // One clock: drive, advance the model at the edge, then compare.
  task automatic tick(input logic sv, input logic [3:0] b, input logic [2:0] l,
                      input logic rst_n = 1'b1);
    bit found;
    int len, val, n;
    logic [8:0] exp_buf;
    sValid = sv; in_bits = b; in_len = l; reset = rst_n;
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); exp_tv = 0; exp_d = 0;
    end else begin
      model_decode(found, len, val);
      if (found) begin
        repeat (len) void'(q.pop_front());
        exp_tv = 1; exp_d = val;
      end else begin
        exp_tv = 0;
      end
      n = (l > 3'd4) ? 4 : int'(l);
      if (sv && n > 0 && q.size() + n <= 9)
        for (int i = n - 1; i >= 0; i--) q.push_back(b[i]);
    end
    #1;
    exp_buf = '0;
    for (int i = 0; i < q.size(); i++) exp_buf[8-i] = q[i];
    chk("tvalid", int'(tvalid), exp_tv);
    if (exp_tv != 0 || !rst_n) chk("data", int'(decodedData), exp_d);
    chk("bit_count", int'(dut.bit_count), q.size());
    chk("shift_buf", int'(dut.shift_buf), int'(exp_buf));
    if (int'(dut.bit_count) > 9) chk("count_bound", int'(dut.bit_count), 9);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) tick(1'b0, 4'h0, 3'd0);
  endtask

  initial begin
    reset = 1'b0; sValid = 1'b0; in_bits = '0; in_len = '0;

    // Reset
    tick(1'b0, 4'h0, 3'd0, 1'b0);
    tick(1'b0, 4'h0, 3'd0, 1'b0);
    chk("rst_data", int'(decodedData), 0);

    // Incomplete then complete codeword
    tick(1'b1, 4'b1111, 3'd4);
    chk("plan1_cnt4", int'(dut.bit_count), 4);
    tick(1'b1, 4'b0010, 3'd3);
    chk("plan1_cnt7", int'(dut.bit_count), 7);
    idle(1);
    chk("plan1_m2", int'(decodedData), -2);
    chk("plan1_cnt2", int'(dut.bit_count), 2);
    idle(1);
    chk("plan1_p1", int'(decodedData), 1);
    idle(1);
    chk("plan1_quiet", int'(tvalid), 0);

    // Leftover bits carried over
    tick(1'b1, 4'b0111, 3'd4);
    idle(2);
    chk("plan2_cnt3", int'(dut.bit_count), 3);
    tick(1'b1, 4'b1100, 3'd4);
    idle(1);
    chk("plan2_p3", int'(decodedData), 3);
    idle(3);

    // Continuous input with overflow
    repeat (5) tick(1'b1, 4'b1000, 3'd4);
    idle(8);

    // Max-length codeword
    tick(1'b1, 4'b1111, 3'd4);
    tick(1'b1, 4'b1111, 3'd4);
    tick(1'b1, 4'b0001, 3'd1);
    chk("plan4_cnt9", int'(dut.bit_count), 9);
    idle(1);
    chk("plan4_p5", int'(decodedData), 5);
    idle(1);

    // -4 codeword and oversize in_len
    tick(1'b1, 4'b1111, 3'd7);
    tick(1'b1, 4'b1111, 3'd6);
    tick(1'b1, 4'b0000, 3'd1);
    idle(2);

    // Reset mid-stream
    tick(1'b1, 4'b0111, 3'd3);
    tick(1'b0, 4'h0, 3'd0, 1'b0);
    chk("plan5_cnt0", int'(dut.bit_count), 0);
    tick(1'b1, 4'b0000, 3'd1);
    idle(1);
    chk("plan5_zero", int'(decodedData), 0);
    idle(1);

    // Random stream, occasional reset
    for (int i = 0; i < 600; i++) begin
      tick(logic'($urandom_range(0, 3) != 0), 4'($urandom), 3'($urandom),
           logic'($urandom_range(0, 60) != 0));
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
